// File: rtl/sd_cmd_master_q.sv
// Queued SD command master: buffers command descriptors in a FIFO and runs each one
// through the command/response handshake, with timeout, CRC/index checks and retry.
module sd_cmd_master_q #(
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT_W   = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                         CLK_PAD_IO,
  input  logic                         RST_PAD_I,
  input  logic                         New_CMD,
  input  logic [13:0]                  CMD_SET_REG,
  input  logic [31:0]                  ARG_REG,
  input  logic [TIMEOUT_W-1:0]         TIMEOUT_REG,
  input  logic                         card_detect,
  output logic                         queue_full,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level,
  output logic                         req_out,
  input  logic                         ack_in,
  output logic [39:0]                  cmd_out,
  input  logic                         req_in,
  output logic                         ack_out,
  input  logic [39:0]                  cmd_in,
  input  logic [7:0]                   serial_status,
  output logic [127:0]                 RESP_REG,
  output logic [15:0]                  STATUS_REG,
  output logic [7:0]                   ERR_INT_REG,
  output logic [7:0]                   NORMAL_INT_REG,
  input  logic                         ERR_INT_RST,
  input  logic                         NORMAL_INT_RST
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 14 + 32 + TIMEOUT_W;
  localparam logic [LW-1:0] DEPTH_L     = LW'(QUEUE_DEPTH);
  localparam logic [7:0]    MAX_RETRY_L = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, SEND_REL, WAIT_RSP, RSP_ACK, CHECK, DONE
  } state_t;

  state_t state, next_state;

  logic [EW-1:0]        mem [QUEUE_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic [13:0]          cur_cmd;
  logic [31:0]          cur_arg;
  logic [TIMEOUT_W-1:0] cur_tmo;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [2:0]           word_cnt;
  logic [7:0]           retry_cnt;
  logic                 crc_acc, end_acc, idx_acc;
  logic                 busy;

  logic q_empty, push, overflow, start, card_abort;
  logic is_long, no_resp, timeout_hit, check_fault, fault, can_retry, give_up, flush;
  logic crc_fault, idx_fault;
  logic [7:0] err_set, norm_set;
  logic unused_bits;

  assign q_empty     = (count == '0);
  assign queue_full  = (count == DEPTH_L);
  assign queue_level = count;
  assign push        = New_CMD && !queue_full;
  assign overflow    = New_CMD && queue_full;
  assign start       = (state == IDLE) && !q_empty && card_detect;
  assign card_abort  = (state != IDLE) && !card_detect;
  assign is_long     = (cur_cmd[1:0] == 2'b10);
  assign no_resp     = (cur_cmd[1:0] == 2'b00);
  assign crc_fault   = cur_cmd[3] && crc_acc;
  assign idx_fault   = cur_cmd[4] && idx_acc;

  // A reply arriving on the last counted cycle is accepted rather than timed out.
  assign timeout_hit = card_detect && (state == WAIT_RSP) && !req_in &&
                       (cur_tmo != '0) && (tmo_cnt == cur_tmo - TIMEOUT_W'(1));
  assign check_fault = card_detect && (state == CHECK) && (crc_fault || idx_fault || end_acc);
  assign fault       = timeout_hit || check_fault;
  assign can_retry   = (retry_cnt < MAX_RETRY_L);
  assign give_up     = fault && !can_retry;
  assign flush       = card_abort || give_up;

  assign STATUS_REG  = {2'b00, cur_cmd[13:8], 4'b0000, retry_cnt[1:0], q_empty, busy};
  assign unused_bits = ^{serial_status[7:2], cur_cmd[7:5], cur_cmd[2], retry_cnt[7:2]};

  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (card_abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) next_state = LOAD;
        LOAD:     next_state = SEND;
        SEND:     if (ack_in) next_state = SEND_REL;
        SEND_REL: if (!ack_in) next_state = no_resp ? DONE : WAIT_RSP;
        WAIT_RSP: begin
          if (req_in)           next_state = RSP_ACK;
          else if (timeout_hit) next_state = can_retry ? LOAD : IDLE;
        end
        RSP_ACK:  if (!req_in) next_state = (is_long && word_cnt < 3'd4) ? WAIT_RSP : CHECK;
        CHECK:    next_state = check_fault ? (can_retry ? LOAD : IDLE) : DONE;
        DONE:     next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    req_out = 1'b0;
    ack_out = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE:    busy    = 1'b0;
      SEND:    req_out = 1'b1;
      RSP_ACK: ack_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_PAD_IO) begin
    if (push) mem[wr_ptr] <= {CMD_SET_REG, ARG_REG, TIMEOUT_REG};
  end

  // A flush coinciding with a push keeps only the newly pushed entry.
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= push ? LW'(1) : '0;
      end else begin
        if (start) rd_ptr <= rd_ptr + AW'(1);
        case ({push, start})
          2'b10:   count <= count + LW'(1);
          2'b01:   count <= count - LW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      cur_cmd   <= '0;
      cur_arg   <= '0;
      cur_tmo   <= '0;
      cmd_out   <= '0;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
      word_cnt  <= '0;
      crc_acc   <= 1'b0;
      end_acc   <= 1'b0;
      idx_acc   <= 1'b0;
      RESP_REG  <= '0;
    end else begin
      if (start) begin
        {cur_cmd, cur_arg, cur_tmo} <= mem[rd_ptr];
        retry_cnt <= '0;
      end
      if (state == LOAD) cmd_out <= {2'b01, cur_cmd[13:8], cur_arg};
      if (fault && can_retry) retry_cnt <= retry_cnt + 8'd1;
      case (state)
        SEND_REL: if (!ack_in) begin
          tmo_cnt  <= '0;
          word_cnt <= '0;
          crc_acc  <= 1'b0;
          end_acc  <= 1'b0;
          idx_acc  <= 1'b0;
        end
        WAIT_RSP: begin
          if (req_in) begin
            word_cnt <= word_cnt + 3'd1;
            crc_acc  <= crc_acc | serial_status[0];
            end_acc  <= end_acc | serial_status[1];
            if (is_long) begin
              case (word_cnt[1:0])
                2'd0: RESP_REG[127:96] <= cmd_in[31:0];
                2'd1: RESP_REG[95:64]  <= cmd_in[31:0];
                2'd2: RESP_REG[63:32]  <= cmd_in[31:0];
                default: RESP_REG[31:0] <= cmd_in[31:0];
              endcase
            end else begin
              RESP_REG[31:0] <= cmd_in[31:0];
              idx_acc <= idx_acc | (cmd_in[39:32] != {2'b00, cur_cmd[13:8]});
            end
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        RSP_ACK: if (!req_in) tmo_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    err_set     = '0;
    norm_set    = '0;
    err_set[0]  = give_up && timeout_hit;
    err_set[1]  = give_up && check_fault && crc_fault;
    err_set[2]  = give_up && check_fault && idx_fault;
    err_set[3]  = give_up && check_fault && end_acc;
    err_set[4]  = card_abort;
    err_set[5]  = flush && !q_empty;
    err_set[6]  = overflow;
    norm_set[0] = (state == DONE) && !card_abort;
    norm_set[1] = (state == DONE) && !card_abort && q_empty;
    norm_set[7] = give_up;
  end

  // Sticky flags; a set event in the same cycle as a clear request survives.
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      ERR_INT_REG    <= '0;
      NORMAL_INT_REG <= '0;
    end else begin
      ERR_INT_REG    <= (ERR_INT_RST ? 8'h00 : ERR_INT_REG) | err_set;
      NORMAL_INT_REG <= (NORMAL_INT_RST ? 8'h00 : NORMAL_INT_REG) | norm_set;
    end
  end

endmodule
